// File: rtl/mac_sequencer_if.sv
// Control/handshake bundle between the MAC sequencer and its DSP datapath + consumer.
// The master side is the sequencer; the slave side is the datapath/consumer environment.
interface mac_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             sub;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       opmode10;
  logic [1:0]       opmode32;
  logic             opmode7;
  logic [47:0]      p_in;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;
  logic             busy;
  logic             done;

  modport master (
    input  start, len, sub, op_valid, p_in, res_ready,
    output op_ready, opmode10, opmode32, opmode7, res_valid, res_data, busy, done
  );

  modport slave (
    output start, len, sub, op_valid, p_in, res_ready,
    input  op_ready, opmode10, opmode32, opmode7, res_valid, res_data, busy, done
  );
endinterface

// File: rtl/mac_sequencer.sv
// Opmode sequencer for a DSP-style multiply-accumulate datapath with P feedback.
// Optional macro MAC_SEQ_ROUND_EN: the first tap selects C on Z as a rounding preload.
module mac_sequencer #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  mac_sequencer_if.master bus
);

  localparam int unsigned       FlushW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(LAT - 1);

  localparam logic [1:0] XZero = 2'b00;
  localparam logic [1:0] XM    = 2'b01;
  localparam logic [1:0] ZP    = 2'b10;
`ifdef MAC_SEQ_ROUND_EN
  localparam logic [1:0] ZFirst = 2'b11;
`else
  localparam logic [1:0] ZFirst = 2'b00;
`endif

  typedef enum logic [1:0] {StIdle, StAcc, StFlush, StOut} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FlushW-1:0] flush_q, flush_d;
  logic              first_q, first_d;
  logic              sub_q, sub_d;
  logic [47:0]       res_q, res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      flush_q <= '0;
      first_q <= 1'b0;
      sub_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      first_q <= first_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    first_d      = first_q;
    sub_d        = sub_q;
    res_d        = res_q;
    bus.op_ready  = 1'b0;
    bus.opmode10  = XZero;
    bus.opmode32  = ZP;
    bus.opmode7   = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = res_q;
    bus.done      = 1'b0;
    bus.busy      = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (bus.start && (bus.len != '0)) begin
          cnt_d   = bus.len;
          sub_d   = bus.sub;
          first_d = 1'b1;
          state_d = StAcc;
        end
      end
      StAcc: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          bus.opmode10 = XM;
          bus.opmode32 = first_q ? ZFirst : ZP;
          bus.opmode7  = sub_q;
          first_d      = 1'b0;
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            flush_d = FlushLoad;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // Capture lands exactly LAT cycles after the last-tap issue cycle.
        if (flush_q == '0) begin
          res_d   = bus.p_in;
          state_d = StOut;
        end else begin
          flush_d = flush_q - FlushW'(1);
        end
      end
      StOut: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          bus.done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural LAT=2 post-adder plus a sum-of-taps reference model.
// Honours MAC_SEQ_ROUND_EN the same way as the design.
module tb_mac_sequencer;
  localparam int unsigned LAT   = 2;
  localparam int unsigned CNT_W = 8;
`ifdef MAC_SEQ_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

  mac_sequencer #(.LAT(LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Post-adder: one input register stage then the P register (LAT = 2 total).
  logic [47:0] m_data, c_val, s_m, p_q, x_v, z_v;
  logic [1:0]  s_om10, s_om32;
  logic        s_om7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_om10 <= 2'b00;
      s_om32 <= 2'b10;
      s_om7  <= 1'b0;
      s_m    <= '0;
      p_q    <= '0;
    end else begin
      s_om10 <= bus.opmode10;
      s_om32 <= bus.opmode32;
      s_om7  <= bus.opmode7;
      s_m    <= m_data;
      p_q    <= s_om7 ? (z_v - x_v) : (z_v + x_v);
    end
  end

  always_comb begin
    case (s_om10)
      2'b00:   x_v = '0;
      2'b01:   x_v = s_m;
      2'b10:   x_v = p_q;
      default: x_v = '0;
    endcase
    case (s_om32)
      2'b00:   z_v = '0;
      2'b01:   z_v = '0;
      2'b10:   z_v = p_q;
      default: z_v = c_val;
    endcase
  end
  assign bus.p_in = p_q;

  int          n_vec = 0;
  int          n_err = 0;
  logic [47:0] ops[$];
  int          tags[$];
  logic [5:0]  codes[$];
  int          obs_lat;
  logic [47:0] obs_res;
  logic        obs_done, obs_busy_after, obs_done_after;

  // Expected {op_ready, opmode10, opmode32, opmode7} in ACC: 0 = stall, 1 = first tap, 2 = later.
  function automatic logic [5:0] exp_code(input int tag, input logic s);
    case (tag)
      1:       return {1'b1, 2'b01, (RoundEn ? 2'b11 : 2'b00), s};
      2:       return {1'b1, 2'b01, 2'b10, s};
      default: return {1'b1, 2'b00, 2'b10, 1'b0};
    endcase
  endfunction

  function automatic logic [47:0] ref_result(input logic s);
    logic [47:0] acc;
    acc = RoundEn ? c_val : 48'd0;
    foreach (ops[i]) acc = s ? (acc - ops[i]) : (acc + ops[i]);
    return acc;
  endfunction

  task automatic run_txn(input logic s, input int stall_at, input int stall_len);
    int issued = 0;
    int stalled = 0;
    bit stall;
    codes.delete();
    tags.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = CNT_W'(ops.size());
    bus.sub   = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    while (issued < ops.size()) begin
      stall        = (issued == stall_at) && (stalled < stall_len);
      bus.op_valid = !stall;
      m_data       = stall ? 48'({$urandom(), $urandom()}) : ops[issued];
      #1;
      codes.push_back({bus.op_ready, bus.opmode10, bus.opmode32, bus.opmode7});
      tags.push_back(stall ? 0 : ((issued == 0) ? 1 : 2));
      @(negedge clk);
      if (stall) stalled++;
      else issued++;
    end
    bus.op_valid = 1'b0;
    obs_lat = 1;
    while (!bus.res_valid && obs_lat < 40) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_res = bus.res_data;
  endtask

  task automatic handoff(input bit with_start);
    bus.res_ready = 1'b1;
    if (with_start) begin
      bus.start = 1'b1;
      bus.len   = CNT_W'(2);
    end
    #1;
    obs_done = bus.done;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    #1;
    obs_busy_after = bus.busy;
    obs_done_after = bus.done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.op_ready, bus.res_valid, bus.done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.busy, bus.op_ready, bus.res_valid, bus.done});
    end
    n_vec++;
    if ({bus.opmode10, bus.opmode32, bus.opmode7} !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_opmode: got %b want 00100", {bus.opmode10, bus.opmode32, bus.opmode7});
    end
    n_vec++;
    if (bus.res_data !== 48'd0) begin
      n_err++;
      $display("FAIL reset_res_data: got %h want 0", bus.res_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_accumulate();
    ops = '{48'd2, 48'd3, 48'd4};
    run_txn(1'b0, -1, 0);
    foreach (codes[i]) begin
      n_vec++;
      if (codes[i] !== exp_code(tags[i], 1'b0)) begin
        n_err++;
        $display("FAIL acc_code[%0d]: got %b want %b", i, codes[i], exp_code(tags[i], 1'b0));
      end
    end
    n_vec++;
    if (obs_lat != LAT + 1) begin
      n_err++;
      $display("FAIL acc_latency: got %0d want %0d", obs_lat, LAT + 1);
    end
    n_vec++;
    if (obs_res !== 48'd9) begin
      n_err++;
      $display("FAIL acc_result: got %h want %h", obs_res, 48'd9);
    end
    handoff(1'b0);
    n_vec++;
    if ({obs_done, obs_busy_after, obs_done_after} !== 3'b100) begin
      n_err++;
      $display("FAIL acc_handoff done/busy/done': got %b want 100",
               {obs_done, obs_busy_after, obs_done_after});
    end
  endtask

  task automatic test_subtract();
    ops = '{48'd5, 48'd7};
    run_txn(1'b1, -1, 0);
    foreach (codes[i]) begin
      n_vec++;
      if (codes[i] !== exp_code(tags[i], 1'b1)) begin
        n_err++;
        $display("FAIL sub_code[%0d]: got %b want %b", i, codes[i], exp_code(tags[i], 1'b1));
      end
    end
    n_vec++;
    if (obs_res !== 48'hFFFF_FFFF_FFF4) begin
      n_err++;
      $display("FAIL sub_result: got %h want %h", obs_res, 48'hFFFF_FFFF_FFF4);
    end
    handoff(1'b0);
    n_vec++;
    if (obs_done !== 1'b1) begin
      n_err++;
      $display("FAIL sub_done: got %b want 1", obs_done);
    end
  endtask

  task automatic test_stall();
    ops = '{48'd2, 48'd3, 48'd4};
    run_txn(1'b0, 1, 2);
    foreach (codes[i]) begin
      n_vec++;
      if (codes[i] !== exp_code(tags[i], 1'b0)) begin
        n_err++;
        $display("FAIL stall_code[%0d]: got %b want %b", i, codes[i], exp_code(tags[i], 1'b0));
      end
    end
    n_vec++;
    if (obs_res !== 48'd9 || obs_lat != LAT + 1) begin
      n_err++;
      $display("FAIL stall_result: got %h lat %0d want %h lat %0d", obs_res, obs_lat, 48'd9,
               LAT + 1);
    end
    handoff(1'b0);
  endtask

  task automatic test_backpressure();
    logic [47:0] want;
    ops = '{48'd11, 48'd22};
    run_txn(1'b0, -1, 0);
    want = ref_result(1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 2);
      bus.len   = CNT_W'(1);
      #1;
      n_vec++;
      if ({bus.res_valid, bus.busy} !== 2'b11 || bus.res_data !== want) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid/busy %b data %h want 11 data %h", k,
                 {bus.res_valid, bus.busy}, bus.res_data, want);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    handoff(1'b1);
    n_vec++;
    if ({obs_done, obs_busy_after} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_handoff done/busy': got %b want 10", {obs_done, obs_busy_after});
    end
  endtask

  task automatic test_reset_mid_acc();
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = CNT_W'(3);
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op_valid = 1'b1;
    m_data       = 48'd5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.op_ready, bus.res_valid, bus.done, bus.opmode10, bus.opmode32,
         bus.opmode7} !== 9'b0000_00100 || bus.res_data !== 48'd0) begin
      n_err++;
      $display("FAIL rst_mid_acc: got %b data %h want 000000100 data 0",
               {bus.busy, bus.op_ready, bus.res_valid, bus.done, bus.opmode10, bus.opmode32,
                bus.opmode7}, bus.res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_after[%0d] done/busy: got %b want 00", k, {bus.done, bus.busy});
      end
      @(negedge clk);
    end
    ops = '{48'd1, 48'd2, 48'd3};
    run_txn(1'b0, -1, 0);
    n_vec++;
    if (obs_res !== ref_result(1'b0)) begin
      n_err++;
      $display("FAIL rst_rerun_result: got %h want %h", obs_res, ref_result(1'b0));
    end
    handoff(1'b0);
  endtask

  task automatic test_rounding();
    logic [47:0] want;
    c_val = 48'h80;
    ops   = '{48'h100};
    want  = RoundEn ? 48'h180 : 48'h100;
    run_txn(1'b0, -1, 0);
    n_vec++;
    if (codes[0] !== exp_code(1, 1'b0)) begin
      n_err++;
      $display("FAIL round_code: got %b want %b", codes[0], exp_code(1, 1'b0));
    end
    n_vec++;
    if (obs_res !== want) begin
      n_err++;
      $display("FAIL round_result: got %h want %h", obs_res, want);
    end
    handoff(1'b0);
    c_val = 48'd0;
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = '0;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.op_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL len_zero busy/op_ready: got %b want 00", {bus.busy, bus.op_ready});
    end
  endtask

  task automatic test_random();
    logic s;
    int   n;
    for (int t = 0; t < 15; t++) begin
      n = $urandom_range(6, 1);
      s = 1'($urandom_range(1, 0));
      c_val = 48'({$urandom(), $urandom()});
      ops.delete();
      for (int j = 0; j < n; j++) ops.push_back(48'({$urandom(), $urandom()}));
      run_txn(s, $urandom_range(n, 0), $urandom_range(3, 0));
      foreach (codes[i]) begin
        n_vec++;
        if (codes[i] !== exp_code(tags[i], s)) begin
          n_err++;
          $display("FAIL rnd%0d_code[%0d]: got %b want %b", t, i, codes[i], exp_code(tags[i], s));
        end
      end
      n_vec++;
      if (obs_res !== ref_result(s) || obs_lat != LAT + 1) begin
        n_err++;
        $display("FAIL rnd%0d_result: got %h lat %0d want %h lat %0d", t, obs_res, obs_lat,
                 ref_result(s), LAT + 1);
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
      handoff(1'b0);
      n_vec++;
      if ({obs_done, obs_busy_after} !== 2'b10) begin
        n_err++;
        $display("FAIL rnd%0d_handoff done/busy': got %b want 10", t, {obs_done, obs_busy_after});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.sub       = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    m_data        = '0;
    c_val         = '0;
    test_reset();
    test_accumulate();
    test_subtract();
    test_stall();
    test_backpressure();
    test_reset_mid_acc();
    test_rounding();
    test_len_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 2: cycles from an issued opmode to its result appearing on p_in; legal range >= 1.
REQ-002 SHALL have parameter CNT_W, default 8: width of the tap-count input.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an accumulation; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of taps; sampled with start.
REQ-007 sub  input  1  accumulate by subtraction; sampled with start.
REQ-008 op_valid  input  1  multiplier operand M is available this cycle.
REQ-009 op_ready  output  1  sequencer consumes M this cycle.
REQ-010 opmode10  output  2  X-mux select: 00=0, 01=M, 10=P, 11=D:A:B.
REQ-011 opmode32  output  2  Z-mux select: 00=0, 01=PCIN, 10=P, 11=C.
REQ-012 opmode7  output  1  post-adder mode: 0 = Z+X, 1 = Z-X.
REQ-013 p_in  input  48  P output of the post-adder stage.
REQ-014 res_valid  output  1  res_data holds a completed result.
REQ-015 res_ready  input  1  downstream accepts the result.
REQ-016 res_data  output  48  captured accumulation result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on result handoff.

Function
REQ-019 SHALL implement the FSM states IDLE, ACC, FLUSH and OUT.
REQ-020 IDLE: start=1 with len!=0 SHALL latch len and sub and go to ACC; start with len=0 SHALL be ignored.
REQ-021 In IDLE, OUT, FLUSH and any ACC cycle with op_valid=0, outputs SHALL be the hold code: opmode10=00, opmode32=10, opmode7=0.
REQ-022 ACC: op_ready SHALL be 1; a tap is issued in a cycle where op_valid=1.
REQ-023 The first issued tap SHALL drive opmode10=01 and opmode32=00; every later tap SHALL drive opmode10=01 and opmode32=10.
REQ-024 Every tap SHALL drive opmode7 equal to the latched sub.
REQ-025 The tap counter SHALL decrement per issued tap; issuing the last tap SHALL move the FSM to FLUSH.
REQ-026 FLUSH SHALL wait so that p_in is captured into res_data exactly LAT cycles after the last-tap issue cycle, then move to OUT.
REQ-027 OUT: res_valid=1 and res_data SHALL be held stable until res_ready=1.
REQ-028 The res_valid & res_ready cycle SHALL pulse done and return the FSM to IDLE.
REQ-029 start while busy SHALL be ignored, including in the same cycle as the OUT handoff.
REQ-030 The result is modulo 2^48; wrap-around SHALL NOT be flagged.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counters 0, res_data=0, res_valid=0, done=0, busy=0, op_ready=0, and opmode at the hold code (00/10/0).
REQ-032 Reset SHALL be honoured in any state; an in-flight accumulation is discarded with no done pulse.

Configuration
REQ-033 With macro MAC_SEQ_ROUND_EN defined, the first tap SHALL drive opmode32=11, preloading C as a rounding constant.
REQ-034 Without MAC_SEQ_ROUND_EN, the first tap SHALL drive opmode32=00; all other behaviour is identical.

Verification
The bench SHALL pair the sequencer with a behavioural post-adder of latency LAT=2.
REQ-035 Accumulate: len=3, sub=0, M=2,3,4 back-to-back -> res_data=9, res_valid 3 cycles after last tap, done pulse on handoff.
REQ-036 Subtract: len=2, sub=1, M=5,7 -> res_data=48'hFFFF_FFFF_FFF4.
REQ-037 Operand stall: len=3, M=2,3,4 with op_valid=0 for 2 cycles after first tap -> hold code during stall, res_data=9.
REQ-038 Backpressure: res_ready=0 for 5 cycles with start=1 pulsed in OUT -> res_valid and res_data stable, start ignored, busy stays 1.
REQ-039 Reset mid-ACC: rst_n=0 after tap 1 of 3 -> immediate IDLE, all outputs at reset values, no done; a new start then runs normally.
REQ-040 Rounding: C=48'h80, len=1, M=48'h100 -> res_data=48'h180 with MAC_SEQ_ROUND_EN defined, 48'h100 without it.
